pick_motion_ctrl: RTL and testbench
===================================

PICK_MOTION_CTRL -- requirements
Module: pick_motion_ctrl

Interface
REQ-001 SHALL provide parameter ACCEL_FRAMES, default 16: consecutive same-key frames before the step doubles.
REQ-002 SHALL provide parameter IDLE_FRAMES, default 120: consecutive no-key frames before demo entry.
REQ-003 SHALL provide parameter DEMO_SEG, default 32: frames per demo pattern segment.
REQ-004 SHALL have port frame_clk, input, 1 bit: frame clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port key_up, input, 1 bit: level, up key held.
REQ-007 SHALL have port key_down, input, 1 bit: level, down key held.
REQ-008 SHALL have port demo_en, input, 1 bit: attract/demo mode permitted.
REQ-009 SHALL have port dir, output, 3 bits: motion command to the pick mover.
REQ-010 SHALL have port mode, output, 2 bits: 00 IDLE, 01 MANUAL, 10 DEMO.
REQ-011 SHALL have port accel, output, 1 bit: high while dir is a 2-step code.

Function
REQ-012 SHALL encode dir as: 000 stop, 001 up-1 (Y -1), 010 down-1 (Y +1), 011 down-2, 100 up-2; codes 101-111 never driven.
REQ-013 SHALL register dir, mode and accel, so each reflects inputs sampled at the same edge (1-frame latency).
REQ-014 SHALL treat the keys as one request: exactly one key high = that direction; both or neither high = no request.
REQ-015 SHALL keep 0..ACCEL_FRAMES saturating counter hold_cnt: same single key as the previous frame -> hold_cnt+1; new or changed direction -> 1; no request -> 0.
REQ-016 SHALL drive a 1-step code while the new hold_cnt < ACCEL_FRAMES and a 2-step code once hold_cnt >= ACCEL_FRAMES.
REQ-017 SHALL keep 0..IDLE_FRAMES saturating counter idle_cnt: +1 each no-request frame; cleared on any request.
REQ-018 SHALL implement states IDLE, MANUAL and DEMO.
REQ-019 IDLE SHALL drive dir 000 and SHALL go to MANUAL on a request.
REQ-020 IDLE SHALL go to DEMO on the edge where idle_cnt reaches IDLE_FRAMES while demo_en=1.
REQ-021 MANUAL SHALL apply REQ-015/016 and SHALL go to IDLE, dir 000, on a no-request frame.
REQ-022 DEMO SHALL loop segments up-1, stop, down-1, stop, each exactly DEMO_SEG frames, starting at segment 0, frame 0.
REQ-023 In DEMO, a request SHALL go to MANUAL on that same edge, with dir from REQ-016 (hold_cnt=1) and the segment counters cleared.
REQ-024 In DEMO, demo_en=0 without a request SHALL go to IDLE with dir 000; a request takes priority over demo_en=0.
REQ-025 With demo_en=0, idle_cnt SHALL still saturate, and a later demo_en=1 SHALL enter DEMO on the next edge.

Reset
REQ-026 Reset SHALL force state IDLE, dir 000, mode 00, accel 0, and all counters 0, immediately and independent of frame_clk.
REQ-027 Reset asserted mid-demo or mid-hold SHALL discard all progress; after release, acceleration and idle timing restart from zero.

Structure
REQ-028 Shared package pick_ctrl_pkg SHALL hold the dir-code enum (STOP, UP1, DN1, DN2, UP2), the mode enum, and the state typedef.
REQ-029 A single sub-module sat_counter (parameterised width and max; clear, increment, value, at_max) SHALL implement hold_cnt, idle_cnt and the demo segment frame counter.

Verification
REQ-030 Reset, then key_up held 20 frames -> dir 001 for frames 1-15, dir 100 with accel=1 for frames 16-20, mode 01.
REQ-031 key_down held 10 frames, then key_up 1 frame -> dir 010 ten times, then 001 with hold_cnt=1 and accel=0.
REQ-032 Both keys held 5 frames -> dir 000, mode 00; idle_cnt keeps counting.
REQ-033 demo_en=1, no keys 120 frames -> mode 10 on edge 120; then 32x 001, 32x 000, 32x 010, 32x 000, repeating.
REQ-034 In DEMO segment 2, press key_down -> mode 01 and dir 010 on that edge; release -> IDLE; DEMO re-entered only after 120 more idle frames.
REQ-035 Assert Reset between edges during DEMO -> dir 000, mode 00 without a clock edge; after release, key_up held 16 frames -> first 100 on frame 16.

Source files
------------

// File: rtl/pick_ctrl_pkg.sv
// Shared types for the pick motion controller: motion codes, mode codes and FSM states.
package pick_ctrl_pkg;

  typedef enum logic [2:0] {
    STOP = 3'b000,
    UP1  = 3'b001,
    DN1  = 3'b010,
    DN2  = 3'b011,
    UP2  = 3'b100
  } dir_e;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_DEMO   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_DEMO
  } state_t;

  localparam int unsigned SEG_W = 2;

  // Demo pattern: up-1, stop, down-1, stop.
  function automatic dir_e demo_dir(input logic [SEG_W-1:0] seg);
    case (seg)
      2'd0:    return UP1;
      2'd2:    return DN1;
      default: return STOP;
    endcase
  endfunction

endpackage

// File: rtl/pick_motion_ctrl_sat_counter.sv
// Saturating up-counter; clear together with increment restarts the count at 1.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic [W-1:0] next_c,
  output logic         at_max_c
);

  logic [W-1:0] value_q;

  assign at_max_c = (value_q == W'(MAX));
  assign value_o  = value_q;

  always_comb begin
    next_c = value_q;
    if (clear_i) begin
      next_c = inc_i ? W'(1) : '0;
    end else if (inc_i && !at_max_c) begin
      next_c = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= next_c;
  end

endmodule

// File: rtl/pick_motion_ctrl.sv
// Pick mover command generator: key-driven motion with hold acceleration,
// idle timeout into a looping demo pattern.
module pick_motion_ctrl
  import pick_ctrl_pkg::*;
#(
  parameter int unsigned ACCEL_FRAMES = 16,
  parameter int unsigned IDLE_FRAMES  = 120,
  parameter int unsigned DEMO_SEG     = 32
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       demo_en,
  output logic [2:0] dir,
  output logic [1:0] mode,
  output logic       accel
);

  localparam int unsigned HOLD_W  = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned IDLE_W  = $clog2(IDLE_FRAMES + 1);
  localparam int unsigned FRAME_W = $clog2(DEMO_SEG + 1);

  state_t           state_q;
  dir_e             dir_q;
  mode_e            mode_q;
  logic             accel_q;
  logic [SEG_W-1:0] seg_q;
  logic             last_up_q;

  logic req_up_c, req_dn_c, req_c, same_c, fast_c, stay_demo_c, enter_demo_c;
  logic hold_clr_c, frame_clr_c, frame_inc_c;
  logic [HOLD_W-1:0]  hold_val, hold_next;
  logic [IDLE_W-1:0]  idle_val, idle_next;
  logic [FRAME_W-1:0] frame_val, frame_next;
  logic hold_at_max, idle_at_max, frame_at_max;
  logic [SEG_W-1:0] seg_adv_c;
  dir_e man_dir_c;
  logic unused_c;

  // Both keys or neither is treated as no request.
  assign req_up_c = key_up & ~key_down;
  assign req_dn_c = key_down & ~key_up;
  assign req_c    = req_up_c | req_dn_c;

  assign same_c     = (hold_val != '0) && (req_up_c == last_up_q);
  assign hold_clr_c = ~req_c | ~same_c;
  assign fast_c     = (hold_next >= HOLD_W'(ACCEL_FRAMES));

  always_comb begin
    man_dir_c = STOP;
    if (req_up_c)      man_dir_c = fast_c ? UP2 : UP1;
    else if (req_dn_c) man_dir_c = fast_c ? DN2 : DN1;
  end

  assign enter_demo_c = demo_en && (idle_next == IDLE_W'(IDLE_FRAMES));
  assign stay_demo_c  = (state_q == ST_DEMO) && !req_c && demo_en;
  assign frame_clr_c  = !stay_demo_c || frame_at_max;
  assign frame_inc_c  = stay_demo_c && !frame_at_max;
  assign seg_adv_c    = frame_at_max ? seg_q + SEG_W'(1) : seg_q;

  assign unused_c = ^{hold_at_max, idle_val, idle_at_max, frame_val, frame_next};

  sat_counter #(.W(HOLD_W), .MAX(ACCEL_FRAMES)) u_hold (
    .clk(frame_clk), .rst(Reset), .clear_i(hold_clr_c), .inc_i(req_c),
    .value_o(hold_val), .next_c(hold_next), .at_max_c(hold_at_max)
  );

  sat_counter #(.W(IDLE_W), .MAX(IDLE_FRAMES)) u_idle (
    .clk(frame_clk), .rst(Reset), .clear_i(req_c), .inc_i(~req_c),
    .value_o(idle_val), .next_c(idle_next), .at_max_c(idle_at_max)
  );

  sat_counter #(.W(FRAME_W), .MAX(DEMO_SEG - 1)) u_frame (
    .clk(frame_clk), .rst(Reset), .clear_i(frame_clr_c), .inc_i(frame_inc_c),
    .value_o(frame_val), .next_c(frame_next), .at_max_c(frame_at_max)
  );

  // Mode FSM with registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= STOP;
      mode_q    <= MODE_IDLE;
      accel_q   <= 1'b0;
      seg_q     <= '0;
      last_up_q <= 1'b0;
    end else begin
      if (req_c) last_up_q <= req_up_c;
      case (state_q)
        ST_MANUAL: begin
          if (req_c) begin
            dir_q   <= man_dir_c;
            accel_q <= fast_c;
          end else begin
            state_q <= ST_IDLE;
            dir_q   <= STOP;
            mode_q  <= MODE_IDLE;
            accel_q <= 1'b0;
          end
        end
        ST_DEMO: begin
          if (req_c) begin
            state_q <= ST_MANUAL;
            dir_q   <= man_dir_c;
            mode_q  <= MODE_MANUAL;
            accel_q <= fast_c;
            seg_q   <= '0;
          end else if (!demo_en) begin
            state_q <= ST_IDLE;
            dir_q   <= STOP;
            mode_q  <= MODE_IDLE;
            accel_q <= 1'b0;
            seg_q   <= '0;
          end else begin
            seg_q <= seg_adv_c;
            dir_q <= demo_dir(seg_adv_c);
          end
        end
        default: begin
          accel_q <= 1'b0;
          if (req_c) begin
            state_q <= ST_MANUAL;
            dir_q   <= man_dir_c;
            mode_q  <= MODE_MANUAL;
            accel_q <= fast_c;
          end else if (enter_demo_c) begin
            state_q <= ST_DEMO;
            dir_q   <= UP1;
            mode_q  <= MODE_DEMO;
            seg_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            dir_q   <= STOP;
            mode_q  <= MODE_IDLE;
          end
        end
      endcase
    end
  end

  assign dir   = dir_q;
  assign mode  = mode_q;
  assign accel = accel_q;

endmodule

// File: tb/tb_pick_motion_ctrl.sv
// Directed vector bench for pick_motion_ctrl with default parameters.
module tb_pick_motion_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic       key_up    = 1'b0;
  logic       key_down  = 1'b0;
  logic       demo_en   = 1'b0;
  logic [2:0] dir;
  logic [1:0] mode;
  logic       accel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] D_STOP = 3'b000, D_UP1 = 3'b001, D_DN1 = 3'b010, D_UP2 = 3'b100;
  localparam logic [1:0] M_IDLE = 2'b00, M_MAN = 2'b01, M_DEMO = 2'b10;

  pick_motion_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .key_up(key_up), .key_down(key_down),
    .demo_en(demo_en), .dir(dir), .mode(mode), .accel(accel)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    bit         rst;
    bit         ku;
    bit         kd;
    bit         de;
    int         n;
    logic [2:0] e_dir;
    logic [1:0] e_mode;
    logic       e_acc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit ku, bit kd, bit de, int n,
                              logic [2:0] ed, logic [1:0] em, logic ea);
    vec_t v;
    v.rst = rst; v.ku = ku; v.kd = kd; v.de = de; v.n = n;
    v.e_dir = ed; v.e_mode = em; v.e_acc = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0d: got %0d expected %0d (t=%0t)", nm, tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int tag,
                         input logic [2:0] ed, input logic [1:0] em, input logic ea);
    chk({nm, ".dir"},   tag, int'(dir),   int'(ed));
    chk({nm, ".mode"},  tag, int'(mode),  int'(em));
    chk({nm, ".accel"}, tag, int'(accel), int'(ea));
  endtask

  // Assert reset between edges, check the outputs clear without an edge, release after one edge.
  task automatic do_reset(input int tag);
    #2;
    Reset    = 1'b1;
    key_up   = 1'b0;
    key_down = 1'b0;
    demo_en  = 1'b0;
    #1;
    chk_out("reset_async", tag, D_STOP, M_IDLE, 1'b0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Accel, direction change, both keys, idle saturation with demo disabled, demo loop.
    vecs.push_back(mk(1, 1, 0, 0,  15, D_UP1,  M_MAN,  1'b0));
    vecs.push_back(mk(0, 1, 0, 0,   5, D_UP2,  M_MAN,  1'b1));
    vecs.push_back(mk(0, 0, 1, 0,  10, D_DN1,  M_MAN,  1'b0));
    vecs.push_back(mk(0, 1, 0, 0,   1, D_UP1,  M_MAN,  1'b0));
    vecs.push_back(mk(0, 1, 1, 0,   5, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 0, 200, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_UP1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_STOP, M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_DN1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_STOP, M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,   5, D_UP1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 0,   1, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,   1, D_UP1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 1, 0, 0,   1, D_UP1,  M_MAN,  1'b0));
    // Idle timeout from reset, key press in segment 2, re-entry after a full idle period.
    vecs.push_back(mk(1, 0, 0, 1, 119, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_UP1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  32, D_STOP, M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,  10, D_DN1,  M_DEMO, 1'b0));
    vecs.push_back(mk(0, 0, 1, 1,   1, D_DN1,  M_MAN,  1'b0));
    vecs.push_back(mk(0, 0, 0, 1,   1, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1, 118, D_STOP, M_IDLE, 1'b0));
    vecs.push_back(mk(0, 0, 0, 1,   1, D_UP1,  M_DEMO, 1'b0));
    // Reset while in demo, then acceleration restarts from zero.
    vecs.push_back(mk(1, 1, 0, 0,  15, D_UP1,  M_MAN,  1'b0));
    vecs.push_back(mk(0, 1, 0, 0,   1, D_UP2,  M_MAN,  1'b1));

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst) do_reset(r);
      key_up   = vecs[r].ku;
      key_down = vecs[r].kd;
      demo_en  = vecs[r].de;
      for (int f = 0; f < vecs[r].n; f++) begin
        @(posedge frame_clk);
        #1;
        chk_out($sformatf("vec%0d.f%0d", r, f), r, vecs[r].e_dir, vecs[r].e_mode, vecs[r].e_acc);
      end
    end

    // Reset mid-hold with key still held: outputs stay cleared while Reset is high.
    key_up = 1'b1;
    for (int f = 0; f < 6; f++) begin
      @(posedge frame_clk);
      #1;
    end
    chk_out("hold_pre", 0, D_UP2, M_MAN, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    chk_out("hold_rst_async", 0, D_STOP, M_IDLE, 1'b0);
    for (int f = 0; f < 2; f++) begin
      @(posedge frame_clk);
      #1;
      chk_out("hold_rst_held", f, D_STOP, M_IDLE, 1'b0);
    end
    Reset = 1'b0;
    for (int f = 1; f <= 17; f++) begin
      @(posedge frame_clk);
      #1;
      if (f < 16) chk_out("hold_restart", f, D_UP1, M_MAN, 1'b0);
      else        chk_out("hold_restart", f, D_UP2, M_MAN, 1'b1);
    end

    // Release then press down in the same idle run: fresh 1-step down.
    key_up = 1'b0;
    @(posedge frame_clk);
    #1;
    chk_out("release", 0, D_STOP, M_IDLE, 1'b0);
    key_down = 1'b1;
    @(posedge frame_clk);
    #1;
    chk_out("down_after_release", 0, D_DN1, M_MAN, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
